// File: rtl/round_sequencer.sv
// Modulus game-round controller: arms/freezes the external seconds counter, enforces the
// per-round time limit, counts rounds and keeps score. Define ROUND_SEQUENCER_BONUS_EN for time bonus.
module round_sequencer #(
    parameter int ROUND_LIMIT = 30,
    parameter int NUM_ROUNDS  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       answer_valid,
    input  logic       answer_correct,
    input  logic [9:0] seconds_in,
    output logic       timer_rst_n,
    output logic       timer_stop,
    output logic [3:0] round,
    output logic [7:0] score,
    output logic [9:0] time_left,
    output logic       round_active,
    output logic       timeout_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, ARM, RUN, PAUSE, RESULT, DONE} state_t;

    localparam logic [9:0] LIMIT      = 10'(ROUND_LIMIT);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t     state, state_nx;
    logic [3:0] round_nx;
    logic [7:0] score_nx;
    logic       timeout_nx;
    logic [9:0] remaining;
    logic [8:0] score_sum;
    logic [7:0] score_plus;
    logic       expired;

    always_comb begin
        expired   = (seconds_in >= LIMIT);
        remaining = expired ? 10'd0 : LIMIT - seconds_in;
`ifdef ROUND_SEQUENCER_BONUS_EN
        // Bonus uses the registered time_left, i.e. the time left one cycle before the answer edge.
        score_sum = {1'b0, score} + 9'd1 + 9'(time_left >> 2);
`else
        score_sum = {1'b0, score} + 9'd1;
`endif
        score_plus = score_sum[8] ? 8'hff : score_sum[7:0];
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_nx   = state;
        round_nx   = round;
        score_nx   = score;
        timeout_nx = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = ARM;
                    score_nx = 8'd0;
                    round_nx = 4'd1;
                end
            end
            ARM: state_nx = RUN;
            RUN: begin
                // Answer outranks timeout, timeout outranks pause.
                if (answer_valid) begin
                    state_nx = RESULT;
                    if (answer_correct) score_nx = score_plus;
                end else if (expired) begin
                    state_nx   = RESULT;
                    timeout_nx = 1'b1;
                end else if (pause) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (!pause) state_nx = RUN;
            end
            RESULT: begin
                if (round == LAST_ROUND) begin
                    state_nx = DONE;
                end else begin
                    state_nx = ARM;
                    round_nx = round + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up with the state itself.
    always_ff @(posedge clk) begin
        // NOTE: state and output registers use non-blocking assignments so all update together at the edge.
        if (!reset) begin
            state         <= IDLE;
            timer_rst_n   <= 1'b0;
            timer_stop    <= 1'b1;
            round         <= 4'd0;
            score         <= 8'd0;
            time_left     <= 10'd0;
            round_active  <= 1'b0;
            timeout_pulse <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_nx;
            round         <= round_nx;
            score         <= score_nx;
            timeout_pulse <= timeout_nx;
            timer_rst_n   <= !(state_nx inside {IDLE, ARM});
            timer_stop    <= (state_nx != RUN);
            round_active  <= (state_nx == RUN);
            game_over     <= (state_nx == DONE);
            time_left     <= (state_nx inside {RUN, PAUSE}) ? remaining : 10'd0;
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with ROUND_LIMIT=5, NUM_ROUNDS=3.
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       answer_valid = 1'b0;
    logic       answer_correct = 1'b0;
    logic [9:0] seconds_in = 10'd0;
    logic       timer_rst_n, timer_stop, round_active, timeout_pulse, game_over;
    logic [3:0] round;
    logic [7:0] score;
    logic [9:0] time_left;

    int total = 0;
    int bad = 0;

    round_sequencer #(.ROUND_LIMIT(5), .NUM_ROUNDS(3)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .answer_valid(answer_valid), .answer_correct(answer_correct), .seconds_in(seconds_in),
        .timer_rst_n(timer_rst_n), .timer_stop(timer_stop), .round(round), .score(score),
        .time_left(time_left), .round_active(round_active), .timeout_pulse(timeout_pulse),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {timer_rst_n, timer_stop, round_active, timeout_pulse, game_over}.
    task automatic test_reset();
        repeat (3) tick();
        total++; if ({timer_rst_n, timer_stop, round_active, timeout_pulse, game_over} !== 5'b01000) begin
            bad++; $display("FAIL reset_flags: got %b want 01000", {timer_rst_n, timer_stop, round_active, timeout_pulse, game_over}); end
        total++; if (round !== 4'd0 || score !== 8'd0 || time_left !== 10'd0) begin
            bad++; $display("FAIL reset_counts: got round=%0d score=%0d time_left=%0d want 0 0 0", round, score, time_left); end
        reset = 1'b1;
        tick();
        total++; if (round_active !== 1'b0 || timer_rst_n !== 1'b0) begin
            bad++; $display("FAIL idle_hold: got active=%b rst_n=%b want 0 0", round_active, timer_rst_n); end
    endtask

    task automatic test_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (timer_rst_n !== 1'b0 || round !== 4'd1 || round_active !== 1'b0) begin
            bad++; $display("FAIL arm: got rst_n=%b round=%0d active=%b want 0 1 0", timer_rst_n, round, round_active); end
        tick();
        total++; if ({timer_rst_n, timer_stop, round_active} !== 3'b101) begin
            bad++; $display("FAIL run_entry: got rst_n/stop/active=%b want 101", {timer_rst_n, timer_stop, round_active}); end
        total++; if (time_left !== 10'd5) begin
            bad++; $display("FAIL run_time_left: got %0d want 5", time_left); end
    endtask

    task automatic test_correct_answer();
        seconds_in = 10'd2;
        tick();
        total++; if (time_left !== 10'd3) begin
            bad++; $display("FAIL time_left_lag: got %0d want 3", time_left); end
        answer_valid = 1'b1; answer_correct = 1'b1;
        tick();
        answer_valid = 1'b0; answer_correct = 1'b0;
        total++; if (score !== 8'd1 || timeout_pulse !== 1'b0) begin
            bad++; $display("FAIL answer_result: got score=%0d timeout=%b want 1 0", score, timeout_pulse); end
        total++; if (round_active !== 1'b0 || timer_stop !== 1'b1 || time_left !== 10'd0) begin
            bad++; $display("FAIL result_outputs: got active=%b stop=%b tl=%0d want 0 1 0", round_active, timer_stop, time_left); end
        tick();
        total++; if (round !== 4'd2 || timer_rst_n !== 1'b0) begin
            bad++; $display("FAIL rearm: got round=%0d rst_n=%b want 2 0", round, timer_rst_n); end
        seconds_in = 10'd0;
        tick();
    endtask

    task automatic test_timeout();
        seconds_in = 10'd3;
        tick();
        total++; if (time_left !== 10'd2 || round_active !== 1'b1) begin
            bad++; $display("FAIL pre_timeout: got tl=%0d active=%b want 2 1", time_left, round_active); end
        seconds_in = 10'd5;
        tick();
        total++; if (timeout_pulse !== 1'b1 || score !== 8'd1 || time_left !== 10'd0) begin
            bad++; $display("FAIL timeout: got pulse=%b score=%0d tl=%0d want 1 1 0", timeout_pulse, score, time_left); end
        tick();
        total++; if (timeout_pulse !== 1'b0 || round !== 4'd3 || timer_rst_n !== 1'b0) begin
            bad++; $display("FAIL timeout_rearm: got pulse=%b round=%0d rst_n=%b want 0 3 0", timeout_pulse, round, timer_rst_n); end
        seconds_in = 10'd0;
        tick();
    endtask

    task automatic test_pause();
        int stop_cycles = 0;
        seconds_in = 10'd1;
        pause = 1'b1;
        tick();
        total++; if (timer_stop !== 1'b1 || round_active !== 1'b0) begin
            bad++; $display("FAIL pause_entry: got stop=%b active=%b want 1 0", timer_stop, round_active); end
        for (int i = 1; i < 100; i++) begin
            if (i == 40) begin answer_valid = 1'b1; answer_correct = 1'b1; end
            if (i == 60) seconds_in = 10'd9;
            if (i == 61) seconds_in = 10'd1;
            tick();
            answer_valid = 1'b0; answer_correct = 1'b0;
            if (timer_stop === 1'b1) stop_cycles++;
            if (i == 40) begin
                total++; if (round_active !== 1'b0 || timeout_pulse !== 1'b0) begin
                    bad++; $display("FAIL pause_answer: got active=%b pulse=%b want 0 0", round_active, timeout_pulse); end
            end
            if (i == 60) begin
                total++; if (time_left !== 10'd0) begin
                    bad++; $display("FAIL time_left_floor: got %0d want 0", time_left); end
            end
        end
        total++; if (stop_cycles !== 99) begin
            bad++; $display("FAIL pause_hold: got %0d stopped cycles want 99", stop_cycles); end
        total++; if (score !== 8'd1) begin
            bad++; $display("FAIL pause_score: got %0d want 1", score); end
        pause = 1'b0;
        tick();
        total++; if (timer_stop !== 1'b0 || round_active !== 1'b1 || time_left !== 10'd4) begin
            bad++; $display("FAIL resume: got stop=%b active=%b tl=%0d want 0 1 4", timer_stop, round_active, time_left); end
    endtask

    task automatic test_answer_and_timeout();
        seconds_in = 10'd5;
        answer_valid = 1'b1; answer_correct = 1'b1;
        tick();
        answer_valid = 1'b0; answer_correct = 1'b0;
        total++; if (score !== 8'd2 || timeout_pulse !== 1'b0) begin
            bad++; $display("FAIL answer_vs_timeout: got score=%0d pulse=%b want 2 0", score, timeout_pulse); end
        tick();
        total++; if (game_over !== 1'b1 || round !== 4'd3 || timer_stop !== 1'b1) begin
            bad++; $display("FAIL done: got over=%b round=%0d stop=%b want 1 3 1", game_over, round, timer_stop); end
        seconds_in = 10'd0;
    endtask

    task automatic test_full_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (score !== 8'd0 || round !== 4'd1 || game_over !== 1'b0) begin
            bad++; $display("FAIL restart: got score=%0d round=%0d over=%b want 0 1 0", score, round, game_over); end
        tick();
        seconds_in = 10'd1;
        for (int r = 1; r <= 3; r++) begin
            if (r == 2) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                total++; if (round !== 4'd2 || round_active !== 1'b1 || score !== 8'd1) begin
                    bad++; $display("FAIL start_ignored: got round=%0d active=%b score=%0d want 2 1 1", round, round_active, score); end
            end
            answer_valid = 1'b1; answer_correct = 1'b1;
            tick();
            answer_valid = 1'b0; answer_correct = 1'b0;
            total++; if (score !== 8'(r)) begin
                bad++; $display("FAIL game_score_r%0d: got %0d want %0d", r, score, r); end
            tick();
            if (r < 3) tick();
        end
        total++; if (game_over !== 1'b1 || round !== 4'd3 || score !== 8'd3) begin
            bad++; $display("FAIL game_end: got over=%b round=%0d score=%0d want 1 3 3", game_over, round, score); end
    endtask

    task automatic test_wrong_answer();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (score !== 8'd0 || round !== 4'd1) begin
            bad++; $display("FAIL done_restart: got score=%0d round=%0d want 0 1", score, round); end
        tick();
        answer_valid = 1'b1; answer_correct = 1'b0;
        tick();
        answer_valid = 1'b0;
        total++; if (score !== 8'd0 || timeout_pulse !== 1'b0 || round_active !== 1'b0) begin
            bad++; $display("FAIL wrong_answer: got score=%0d pulse=%b active=%b want 0 0 0", score, timeout_pulse, round_active); end
        tick();
        tick();
        answer_valid = 1'b1; answer_correct = 1'b1;
        tick();
        answer_valid = 1'b0; answer_correct = 1'b0;
        total++; if (score !== 8'd1 || round !== 4'd2) begin
            bad++; $display("FAIL second_answer: got score=%0d round=%0d want 1 2", score, round); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_round();
        seconds_in = 10'd2;
        tick();
        total++; if (round_active !== 1'b1 || round !== 4'd3 || time_left !== 10'd3) begin
            bad++; $display("FAIL pre_reset: got active=%b round=%0d tl=%0d want 1 3 3", round_active, round, time_left); end
        reset = 1'b0;
        tick();
        total++; if ({timer_rst_n, timer_stop, round_active, timeout_pulse, game_over} !== 5'b01000) begin
            bad++; $display("FAIL midreset_flags: got %b want 01000", {timer_rst_n, timer_stop, round_active, timeout_pulse, game_over}); end
        total++; if (round !== 4'd0 || score !== 8'd0 || time_left !== 10'd0) begin
            bad++; $display("FAIL midreset_counts: got round=%0d score=%0d tl=%0d want 0 0 0", round, score, time_left); end
        reset = 1'b1;
        tick();
        total++; if (round_active !== 1'b0 || round !== 4'd0) begin
            bad++; $display("FAIL post_reset_idle: got active=%b round=%0d want 0 0", round_active, round); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_correct_answer();
        test_timeout();
        test_pause();
        test_answer_and_timeout();
        test_full_game();
        test_wrong_answer();
        test_reset_mid_round();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
